// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, the PC source select and the alignment rules.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_DROP,
        ST_HALT
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEL_SEQ,
        PC_SEL_REDIRECT,
        PC_SEL_FLUSH
    } pc_sel_t;

    localparam int unsigned PC_INCR    = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    // Instructions are word aligned; any set low address bit is a fault.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return (lsbs & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-value mux (sequential, redirect, flush).
// Loads only when load is asserted; resets asynchronously to RESET_PC.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  pc_sel_t         sel,
    input  logic [XLEN-1:0] redirect_target,
    input  logic [XLEN-1:0] flush_pc,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;

    always_comb begin
        pc_next = pc_q + XLEN'(PC_INCR);
        case (sel)
            PC_SEL_SEQ:      pc_next = pc_q + XLEN'(PC_INCR);
            PC_SEL_REDIRECT: pc_next = redirect_target;
            PC_SEL_FLUSH:    pc_next = flush_pc;
            default:         pc_next = pc_q + XLEN'(PC_INCR);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= pc_next;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, runs a single-outstanding
// req/gnt/rvalid fetch, holds the fetched word until the core retires it.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic            fetch_err,
    output logic [31:0]     retired_cnt
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic            pc_load;
    pc_sel_t         pc_sel;
    logic            retire;
    logic            err_set;
    logic            latch_instr;
    logic            flush_taken;

    logic            imem_req_q;
    logic            instr_valid_q;
    logic            halted_q;
    logic            fetch_err_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic [31:0]     retired_q;
    logic [XLEN-1:0] pc_cur;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .load            (pc_load),
        .sel             (pc_sel),
        .redirect_target (redirect_target),
        .flush_pc        (flush_pc),
        .pc              (pc_cur)
    );

    always_comb begin
        state_d     = state_q;
        pc_load     = 1'b0;
        pc_sel      = PC_SEL_SEQ;
        retire      = 1'b0;
        err_set     = 1'b0;
        latch_instr = 1'b0;
        flush_taken = flush && (state_q inside {ST_FETCH, ST_WAIT, ST_ISSUE, ST_DROP});

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (flush) begin
                    pc_load = 1'b1;
                    pc_sel  = PC_SEL_FLUSH;
                    // A grant in the flush cycle leaves a response in flight.
                    state_d = imem_gnt ? ST_DROP : ST_FETCH;
                end else if (imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    pc_load = 1'b1;
                    pc_sel  = PC_SEL_FLUSH;
                    state_d = imem_rvalid ? ST_FETCH : ST_DROP;
                end else if (imem_rvalid) begin
                    latch_instr = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    pc_load = 1'b1;
                    pc_sel  = PC_SEL_FLUSH;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    retire = 1'b1;
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (redirect_valid) begin
                        if (is_misaligned(redirect_target[1:0])) begin
                            err_set = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            pc_load = 1'b1;
                            pc_sel  = PC_SEL_REDIRECT;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        pc_load = 1'b1;
                        pc_sel  = PC_SEL_SEQ;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DROP: begin
                if (flush) begin
                    pc_load = 1'b1;
                    pc_sel  = PC_SEL_FLUSH;
                end
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A misaligned flush target overrides every flush transition above.
        if (flush_taken && is_misaligned(flush_pc[1:0])) begin
            pc_load = 1'b0;
            err_set = 1'b1;
            state_d = ST_HALT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_err_q   <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= (state_d == ST_FETCH);
            instr_valid_q <= (state_d == ST_ISSUE);
            halted_q      <= (state_d == ST_HALT);
            if (err_set) begin
                fetch_err_q <= 1'b1;
            end
            if (latch_instr) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc_cur;
            end
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_cur;
    assign pc          = pc_cur;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;
    assign fetch_err   = fetch_err_q;
    assign retired_cnt = retired_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls instruction fetch for the RISC-V core: owns the program counter, issues one request at a time to instruction memory over a req/gnt/rvalid handshake, and presents each fetched instruction to the execute stage. It selects the next PC from sequential (+4), redirect (branch/jump), or flush (trap/debug) sources, and stops in a sticky HALT state on an explicit halt or a misaligned target. It sits between the instruction memory port and the decode/execute logic.

## Interface
Parameters:
- XLEN, 32, address and data width
- RESET_PC, 32'h0000_0000, PC value loaded by reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held until imem_gnt
- imem_addr  out  XLEN  fetch address; equals pc
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instruction available to core
- instr  out  32  held instruction word
- instr_pc  out  XLEN  PC of held instruction
- instr_ready  in  1  core retires held instruction this cycle
- redirect_valid  in  1  sampled with retire; take redirect_target
- redirect_target  in  XLEN  branch/jump target
- halt_req  in  1  sampled with retire; stop after this instruction
- flush  in  1  asynchronous-to-pipeline redirect (trap/debug), any state
- flush_pc  in  XLEN  flush target
- pc  out  XLEN  current fetch PC
- halted  out  1  in HALT state
- fetch_err  out  1  sticky; halted due to misaligned target
- retired_cnt  out  32  retired instruction count

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, DROP, HALT.
- Reset (async, rst=0): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, retired_cnt=0; all 1-bit outputs 0.
- IDLE: unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. imem_gnt=1 -> WAIT.
- WAIT: imem_rvalid=1 -> latch instr=imem_rdata, instr_pc=pc -> ISSUE.
- ISSUE: instr_valid=1. On instr_ready: retired_cnt+1 (wraps); then priority halt_req -> HALT; else redirect_valid -> target[1:0]!=0 ? (fetch_err=1, HALT) : (pc=target, FETCH); else pc=pc+4 (mod 2^XLEN) -> FETCH.
- DROP: waits for the outstanding response; imem_rvalid=1 -> discard data -> FETCH. No request issued.
- flush (highest priority, ignored in HALT and IDLE): pc=flush_pc. FETCH without gnt -> stay FETCH (new addr next cycle). FETCH with gnt same cycle, or WAIT without rvalid -> DROP. WAIT with rvalid -> discard, FETCH. ISSUE -> FETCH, no retire counted even if instr_ready=1. Misaligned flush_pc -> fetch_err=1, HALT.
- HALT: imem_req=0, instr_valid=0, halted=1; exit only by reset.

## Timing
- Zero-wait memory (gnt in FETCH, rvalid next cycle): FETCH, WAIT, ISSUE = 3 cycles per instruction min.
- imem_addr stable while imem_req=1 and not granted, except on flush.
- All outputs registered or decoded from state only; no combinational path from instr_ready/redirect/flush to imem_req.
- pc update and retired_cnt increment visible the cycle after the retire edge.
- At most one outstanding memory transaction.

## Structure
- Package fetch_pkg: state enum fetch_state_t, PC_INCR=4, alignment mask constant.
- One sub-module: fetch_pc_reg (PC register with async active-low reset to RESET_PC, load enable and next-value mux).

## Test plan
- Reset release, zero-wait memory -> addresses 0x0, 0x4, 0x8 requested; instr_valid every 3rd cycle; retired_cnt=3 after three retires.
- Redirect at retire with target 0x100 -> next imem_addr=0x100; target 0x102 -> halted=1, fetch_err=1, imem_req=0.
- flush to 0x200 while in WAIT, rvalid two cycles later with 0xDEADBEEF -> word discarded, next request at 0x200, instr never shows 0xDEADBEEF.
- gnt held low 5 cycles -> imem_req and imem_addr stable throughout; pc unchanged.
- halt_req with retire at PC 0x8 -> retired_cnt increments, halted=1, no further requests; rst pulse mid-WAIT -> pc=RESET_PC, all outputs 0 immediately.
- pc=0xFFFF_FFFC sequential retire -> pc wraps to 0x0; retired_cnt=0xFFFF_FFFF retire -> 0x0.
